vend_dispense: RTL

//  Dispense-side controller for the vending FSM. Accepts one dispense request (product

---
 rtl/vend_dispense.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/vend_dispense.sv
// Dispense-side controller: runs the product motor to its home sensor, then ejects
// change coins one at a time, confirming each on the exit sensor, with a watchdog per step.
module vend_dispense #(
    parameter int CHG_W     = 3,
    parameter int PULSE_LEN = 4,
    parameter int TMR_W     = 8,
    parameter int TIMEOUT   = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_product,
    input  logic [CHG_W-1:0] req_change,
    output logic             ready,
    output logic             motor_on,
    input  logic             motor_home,
    output logic             coin_eject,
    input  logic             coin_sensed,
    output logic [CHG_W-1:0] coins_left,
    output logic             done,
    output logic             fault,
    output logic [1:0]       fault_code,
    input  logic             fault_clr
);

    typedef enum logic [2:0] {
        IDLE,
        MOTOR,
        COIN_PULSE,
        COIN_WAIT,
        DONE,
        FAULT
    } state_t;

    // Timer restarts at 0 on every state entry, so timer == LAST marks the final allowed cycle.
    localparam logic [TMR_W-1:0] TMO_LAST   = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_LEN - 1);

    state_t           state;
    logic [TMR_W-1:0] timer;

    assign ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            timer      <= '0;
            motor_on   <= 1'b0;
            coin_eject <= 1'b0;
            coins_left <= '0;
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (req_valid) begin
                        coins_left <= req_change;
                        if (req_product) begin
                            state    <= MOTOR;
                            motor_on <= 1'b1;
                        end else if (req_change != '0) begin
                            state      <= COIN_PULSE;
                            coin_eject <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                MOTOR: begin
                    timer <= timer + 1'b1;
                    if (motor_home) begin
                        motor_on <= 1'b0;
                        timer    <= '0;
                        if (coins_left != '0) begin
                            state      <= COIN_PULSE;
                            coin_eject <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else if (timer == TMO_LAST) begin
                        motor_on   <= 1'b0;
                        timer      <= '0;
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= 2'b01;
                    end
                end

                COIN_PULSE: begin
                    timer <= timer + 1'b1;
                    if (timer == PULSE_LAST) begin
                        coin_eject <= 1'b0;
                        timer      <= '0;
                        state      <= COIN_WAIT;
                    end
                end

                COIN_WAIT: begin
                    timer <= timer + 1'b1;
                    if (coin_sensed) begin
                        timer <= '0;
                        if (coins_left != '0)
                            coins_left <= coins_left - 1'b1;
                        if (coins_left <= CHG_W'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= COIN_PULSE;
                            coin_eject <= 1'b1;
                        end
                    end else if (timer == TMO_LAST) begin
                        timer      <= '0;
                        state      <= FAULT;
                        fault      <= 1'b1;
                        fault_code <= 2'b10;
                    end
                end

                DONE: begin
                    timer <= '0;
                    state <= IDLE;
                end

                FAULT: begin
                    timer <= '0;
                    if (fault_clr) begin
                        state      <= IDLE;
                        fault      <= 1'b0;
                        fault_code <= 2'b00;
                        coins_left <= '0;
                    end
                end

                default: begin
                    timer      <= '0;
                    state      <= IDLE;
                    motor_on   <= 1'b0;
                    coin_eject <= 1'b0;
                end
            endcase
        end
    end

endmodule
